// File: rtl/lab_cu_pro_pkg.sv
// lab_cpu_pkg: opcode, state and A-source encodings shared by the accumulator CPU control unit.
package lab_cpu_pkg;

    localparam logic [2:0] OP_LDA  = 3'b000;
    localparam logic [2:0] OP_STA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_IN   = 3'b100;
    localparam logic [2:0] OP_JZ   = 3'b101;
    localparam logic [2:0] OP_JPOS = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_LDA    = 4'd2;
    localparam logic [3:0] S_STA    = 4'd3;
    localparam logic [3:0] S_ADD    = 4'd4;
    localparam logic [3:0] S_SUB    = 4'd5;
    localparam logic [3:0] S_INWAIT = 4'd6;
    localparam logic [3:0] S_INREL  = 4'd7;
    localparam logic [3:0] S_JZ     = 4'd8;
    localparam logic [3:0] S_JPOS   = 4'd9;
    localparam logic [3:0] S_HALT   = 4'd10;

    localparam logic [1:0] ASEL_ALU = 2'd0;
    localparam logic [1:0] ASEL_IN  = 2'd1;
    localparam logic [1:0] ASEL_MEM = 2'd2;

    typedef struct packed {
        logic       irload;
        logic       jmpmux;
        logic       pcload;
        logic       meminst;
        logic       memwr;
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       halt;
    } ctrl_t;

    // Execute state entered from DECODE for each opcode; IN starts by waiting for the key.
    function automatic logic [3:0] op_state(input logic [2:0] op);
        case (op)
            OP_LDA:  op_state = S_LDA;
            OP_STA:  op_state = S_STA;
            OP_ADD:  op_state = S_ADD;
            OP_SUB:  op_state = S_SUB;
            OP_IN:   op_state = S_INWAIT;
            OP_JZ:   op_state = S_JZ;
            OP_JPOS: op_state = S_JPOS;
            default: op_state = S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/lab_cu_pro_outdec.sv
// lab_cu_outdec: combinational strobe decoder; Moore per state, Mealy in INWAIT, JZ and JPOS.
module lab_cu_outdec
    import lab_cpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic       enter,
    input  logic       aeq0,
    input  logic       apos,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irload = 1'b1;
                ctrl.pcload = 1'b1;
            end
            S_DECODE: ctrl.meminst = 1'b1;
            S_LDA: begin
                ctrl.meminst = 1'b1;
                ctrl.asel    = ASEL_MEM;
                ctrl.aload   = 1'b1;
            end
            S_STA: begin
                ctrl.meminst = 1'b1;
                ctrl.memwr   = 1'b1;
            end
            S_ADD, S_SUB: begin
                ctrl.meminst = 1'b1;
                ctrl.asel    = ASEL_ALU;
                ctrl.aload   = 1'b1;
                ctrl.sub     = (state == S_SUB);
            end
            S_INWAIT: begin
                ctrl.asel  = ASEL_IN;
                ctrl.aload = enter;
            end
            S_JZ: begin
                ctrl.jmpmux = 1'b1;
                ctrl.pcload = aeq0;
            end
            S_JPOS: begin
                ctrl.jmpmux = 1'b1;
                ctrl.pcload = apos;
            end
            S_HALT: ctrl.halt = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/lab_cu_pro.sv
// lab_cu_pro: fetch/decode/execute sequencer for the 8-bit accumulator processor.
module lab_cu_pro
    import lab_cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    ctrl_t      ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = op_state(IR75);
            S_INWAIT: state_d = Enter ? S_INREL : S_INWAIT;
            // Held key parks here so a single press loads A only once.
            S_INREL:  state_d = Enter ? S_INREL : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    lab_cu_outdec u_outdec (
        .state (state_q),
        .enter (Enter),
        .aeq0  (Aeq0),
        .apos  (Apos),
        .ctrl  (ctrl)
    );

    assign IRload  = ctrl.irload;
    assign JMPmux  = ctrl.jmpmux;
    assign PCload  = ctrl.pcload;
    assign Meminst = ctrl.meminst;
    assign MemWr   = ctrl.memwr;
    assign Asel    = ctrl.asel;
    assign Aload   = ctrl.aload;
    assign Sub     = ctrl.sub;
    assign Halt    = ctrl.halt;
    assign state   = state_q;

endmodule

// File: tb/tb_lab_cu_pro.sv
// tb_lab_cu_pro: directed per-instruction scenarios with hand-computed state and strobe expectations.
module tb_lab_cu_pro;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] IR75  = 3'b000;
    logic       Aeq0  = 1'b0;
    logic       Apos  = 1'b0;
    logic       Enter = 1'b0;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    lab_cu_pro dut (
        .clock   (clock),
        .reset   (reset),
        .IR75    (IR75),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .Enter   (Enter),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Asel    (Asel),
        .Aload   (Aload),
        .Sub     (Sub),
        .Halt    (Halt),
        .state   (state)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++;
        if ({IRload, PCload, Halt, MemWr, Aload} !== 5'b11000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=11000", {IRload, PCload, Halt, MemWr, Aload});
        end
        tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_hold got=%0d exp=0", state); end
        reset = 1'b1;
        #1;
        checks++;
        if ({IRload, PCload, JMPmux, Meminst} !== 4'b1100) begin
            errors++; $display("FAIL fetch_strobes got=%b exp=1100", {IRload, PCload, JMPmux, Meminst});
        end
    endtask

    task automatic test_lda;
        IR75 = 3'b000;
        tick();
        checks++;
        if (state !== 4'd1 || Meminst !== 1'b1 || Aload !== 1'b0 || IRload !== 1'b0) begin
            errors++; $display("FAIL lda_decode state=%0d meminst=%b aload=%b irload=%b exp 1/1/0/0", state, Meminst, Aload, IRload);
        end
        tick();
        checks++;
        if (state !== 4'd2 || Aload !== 1'b1 || Asel !== 2'd2 || MemWr !== 1'b0 || Meminst !== 1'b1) begin
            errors++; $display("FAIL lda_exec state=%0d aload=%b asel=%0d memwr=%b meminst=%b exp 2/1/2/0/1", state, Aload, Asel, MemWr, Meminst);
        end
        tick();
        checks++;
        if (state !== 4'd0 || Aload !== 1'b0) begin
            errors++; $display("FAIL lda_return state=%0d aload=%b exp 0/0", state, Aload);
        end
    endtask

    task automatic test_sta;
        IR75 = 3'b001;
        tick();
        checks++;
        if (MemWr !== 1'b0) begin errors++; $display("FAIL sta_decode_memwr got=%b exp=0", MemWr); end
        tick();
        checks++;
        if (state !== 4'd3 || MemWr !== 1'b1 || Meminst !== 1'b1 || Aload !== 1'b0) begin
            errors++; $display("FAIL sta_exec state=%0d memwr=%b meminst=%b aload=%b exp 3/1/1/0", state, MemWr, Meminst, Aload);
        end
        tick();
        checks++;
        if (state !== 4'd0 || MemWr !== 1'b0) begin
            errors++; $display("FAIL sta_return state=%0d memwr=%b exp 0/0", state, MemWr);
        end
    endtask

    task automatic test_alu(input logic [2:0] op, input logic [3:0] exp_state, input logic exp_sub);
        IR75 = op;
        tick();
        tick();
        checks++;
        if (state !== exp_state || Sub !== exp_sub || Asel !== 2'd0 || Aload !== 1'b1 || Meminst !== 1'b1 || MemWr !== 1'b0) begin
            errors++; $display("FAIL alu_exec op=%0d state=%0d sub=%b asel=%0d aload=%b meminst=%b memwr=%b exp %0d/%b/0/1/1/0",
                               op, state, Sub, Asel, Aload, Meminst, MemWr, exp_state, exp_sub);
        end
        tick();
        checks++;
        if (state !== 4'd0 || Sub !== 1'b0) begin
            errors++; $display("FAIL alu_return state=%0d sub=%b exp 0/0", state, Sub);
        end
    endtask

    task automatic test_in;
        IR75  = 3'b100;
        Enter = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 4'd6 || Aload !== 1'b0 || Asel !== 2'd1) begin
                errors++; $display("FAIL in_wait cyc=%0d state=%0d aload=%b asel=%0d exp 6/0/1", i, state, Aload, Asel);
            end
            if (i < 4) tick();
        end
        Enter = 1'b1;
        #1;
        checks++;
        if (state !== 4'd6 || Aload !== 1'b1 || Asel !== 2'd1) begin
            errors++; $display("FAIL in_load state=%0d aload=%b asel=%0d exp 6/1/1", state, Aload, Asel);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (state !== 4'd7 || Aload !== 1'b0 || Asel !== 2'd0) begin
                errors++; $display("FAIL in_rel cyc=%0d state=%0d aload=%b asel=%0d exp 7/0/0", i, state, Aload, Asel);
            end
        end
        Enter = 1'b0;
        tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL in_return got=%0d exp=0", state); end
    endtask

    task automatic test_branch(input logic [2:0] op, input logic [3:0] exp_state);
        IR75 = op;
        Aeq0 = (op == 3'b101);
        Apos = (op == 3'b110);
        tick();
        tick();
        checks++;
        if (state !== exp_state || PCload !== 1'b1 || JMPmux !== 1'b1) begin
            errors++; $display("FAIL br_taken op=%0d state=%0d pcload=%b jmpmux=%b exp %0d/1/1", op, state, PCload, JMPmux, exp_state);
        end
        Aeq0 = (op != 3'b101);
        Apos = (op != 3'b110);
        #1;
        checks++;
        if (PCload !== 1'b0 || JMPmux !== 1'b1) begin
            errors++; $display("FAIL br_nottaken op=%0d pcload=%b jmpmux=%b exp 0/1", op, PCload, JMPmux);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL br_return op=%0d got=%0d exp=0", op, state); end
        Aeq0 = 1'b0;
        Apos = 1'b0;
    endtask

    task automatic test_in_reset;
        IR75  = 3'b100;
        Enter = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || Asel !== 2'd0) begin
            errors++; $display("FAIL in_abort state=%0d asel=%0d exp 0/0", state, Asel);
        end
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_halt;
        IR75 = 3'b111;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (state !== 4'd10 || Halt !== 1'b1 ||
                {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel} !== 9'b0) begin
                errors++; $display("FAIL halt_hold cyc=%0d state=%0d halt=%b strobes=%b exp 10/1/000000000", i, state, Halt,
                                   {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel});
            end
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || Halt !== 1'b0 || IRload !== 1'b1) begin
            errors++; $display("FAIL halt_reset state=%0d halt=%b irload=%b exp 0/0/1", state, Halt, IRload);
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL halt_restart got=%0d exp=1", state); end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sta();
        test_alu(3'b011, 4'd5, 1'b1);
        test_alu(3'b010, 4'd4, 1'b0);
        test_in();
        test_branch(3'b101, 4'd8);
        test_branch(3'b110, 4'd9);
        test_in_reset();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
